decode_queue: RTL and testbench

//  Decode stage between fetch and execute. Decodes one 32-bit RV64I(+M) instruction per cycle into a

---
 rtl/decode_queue_pkg.sv | 46 ++++
 rtl/decode_queue_inst_decoder.sv | 203 ++++++++++++++++++++
 rtl/decode_queue.sv | 95 +++++++++
 tb/tb_decode_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared types for the decode stage: operation enum, decoded record and base opcodes.
package decode_queue_pkg;

  localparam int unsigned DecXlen = 64;

  typedef logic [31:0] inst_t;

  typedef enum logic [5:0] {
    NOP, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDIW, SLLIW, SRLIW, SRAIW,
    ADDW, SUBW, SLLW, SRLW, SRAW,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    MULW, DIVW, DIVUW, REMW, REMUW
  } op_e;

  // Immediate/operand layout; the Sh formats carry a zero-extended shift amount.
  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtSh6, FmtSh5} fmt_e;

  typedef struct packed {
    logic [DecXlen-1:0] pc;
    op_e                op;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [DecXlen-1:0] imm;
    logic               illegal;
  } decoded_t;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

endpackage

// File: rtl/decode_queue_inst_decoder.sv
// Combinational RV64I(+M) decoder: one raw instruction word to op, registers and immediate.
module decode_queue_inst_decoder
  import decode_queue_pkg::*;
#(
  parameter int unsigned XLEN     = DecXlen,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic [31:0]     inst,
  output op_e             op,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [5:0] funct6;
  logic [2:0] funct3;
  logic       m_sel;
  op_e        op_raw;
  fmt_e       fmt;
  logic       hit;
  logic [XLEN-1:0] imm_raw;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign funct6 = inst[31:26];
  assign m_sel  = ENABLE_M && (funct7 == 7'h01);

  always_comb begin
    op_raw = NOP;
    fmt    = FmtR;
    hit    = 1'b1;
    case (opcode)
      OPC_LUI:   begin op_raw = LUI;   fmt = FmtU; end
      OPC_AUIPC: begin op_raw = AUIPC; fmt = FmtU; end
      OPC_JAL:   begin op_raw = JAL;   fmt = FmtJ; end
      OPC_JALR:  begin op_raw = JALR;  fmt = FmtI; hit = (funct3 == 3'd0); end
      OPC_BRANCH: begin
        fmt = FmtB;
        case (funct3)
          3'd0: op_raw = BEQ;
          3'd1: op_raw = BNE;
          3'd4: op_raw = BLT;
          3'd5: op_raw = BGE;
          3'd6: op_raw = BLTU;
          3'd7: op_raw = BGEU;
          default: hit = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        fmt = FmtI;
        case (funct3)
          3'd0: op_raw = LB;
          3'd1: op_raw = LH;
          3'd2: op_raw = LW;
          3'd3: op_raw = LD;
          3'd4: op_raw = LBU;
          3'd5: op_raw = LHU;
          3'd6: op_raw = LWU;
          default: hit = 1'b0;
        endcase
      end
      OPC_STORE: begin
        fmt = FmtS;
        case (funct3)
          3'd0: op_raw = SB;
          3'd1: op_raw = SH;
          3'd2: op_raw = SW;
          3'd3: op_raw = SD;
          default: hit = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        fmt = FmtI;
        case (funct3)
          3'd0: op_raw = ADDI;
          3'd2: op_raw = SLTI;
          3'd3: op_raw = SLTIU;
          3'd4: op_raw = XORI;
          3'd6: op_raw = ORI;
          3'd7: op_raw = ANDI;
          3'd1: begin op_raw = SLLI; fmt = FmtSh6; hit = (funct6 == 6'h00); end
          default: begin
            fmt = FmtSh6;
            if (funct6 == 6'h00)      op_raw = SRLI;
            else if (funct6 == 6'h10) op_raw = SRAI;
            else                      hit = 1'b0;
          end
        endcase
      end
      OPC_OP_IMM_32: begin
        fmt = FmtSh5;
        case (funct3)
          3'd0: begin op_raw = ADDIW; fmt = FmtI; end
          3'd1: begin op_raw = SLLIW; hit = (funct7 == 7'h00); end
          3'd5: begin
            if (funct7 == 7'h00)      op_raw = SRLIW;
            else if (funct7 == 7'h20) op_raw = SRAIW;
            else                      hit = 1'b0;
          end
          default: hit = 1'b0;
        endcase
      end
      OPC_OP: begin
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: op_raw = ADD;
            3'd1: op_raw = SLL;
            3'd2: op_raw = SLT;
            3'd3: op_raw = SLTU;
            3'd4: op_raw = XOR;
            3'd5: op_raw = SRL;
            3'd6: op_raw = OR;
            default: op_raw = AND;
          endcase
        end else if (funct7 == 7'h20) begin
          case (funct3)
            3'd0: op_raw = SUB;
            3'd5: op_raw = SRA;
            default: hit = 1'b0;
          endcase
        end else if (m_sel) begin
          case (funct3)
            3'd0: op_raw = MUL;
            3'd1: op_raw = MULH;
            3'd2: op_raw = MULHSU;
            3'd3: op_raw = MULHU;
            3'd4: op_raw = DIV;
            3'd5: op_raw = DIVU;
            3'd6: op_raw = REM;
            default: op_raw = REMU;
          endcase
        end else begin
          hit = 1'b0;
        end
      end
      OPC_OP_32: begin
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: op_raw = ADDW;
            3'd1: op_raw = SLLW;
            3'd5: op_raw = SRLW;
            default: hit = 1'b0;
          endcase
        end else if (funct7 == 7'h20) begin
          case (funct3)
            3'd0: op_raw = SUBW;
            3'd5: op_raw = SRAW;
            default: hit = 1'b0;
          endcase
        end else if (m_sel) begin
          case (funct3)
            3'd0: op_raw = MULW;
            3'd4: op_raw = DIVW;
            3'd5: op_raw = DIVUW;
            3'd6: op_raw = REMW;
            3'd7: op_raw = REMUW;
            default: hit = 1'b0;
          endcase
        end else begin
          hit = 1'b0;
        end
      end
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    case (fmt)
      FmtI:    imm_raw = {{(XLEN-12){inst[31]}}, inst[31:20]};
      FmtS:    imm_raw = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      FmtB:    imm_raw = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FmtU:    imm_raw = {{(XLEN-32){inst[31]}}, inst[31:12], 12'h000};
      FmtJ:    imm_raw = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21],
                          1'b0};
      FmtSh6:  imm_raw = {{(XLEN-6){1'b0}}, inst[25:20]};
      FmtSh5:  imm_raw = {{(XLEN-5){1'b0}}, inst[24:20]};
      default: imm_raw = '0;
    endcase
  end

  // Illegal words collapse to an all-zero NOP record so nothing downstream sees stale fields.
  always_comb begin
    illegal = !hit || (inst[1:0] != 2'b11);
    op      = NOP;
    rd      = '0;
    rs1     = '0;
    rs2     = '0;
    imm     = '0;
    if (!illegal) begin
      op  = op_raw;
      rd  = (fmt == FmtS || fmt == FmtB) ? 5'd0 : inst[11:7];
      rs1 = inst[19:15];
      rs2 = (fmt == FmtR || fmt == FmtS || fmt == FmtB) ? inst[24:20] : 5'd0;
      imm = imm_raw;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes one instruction per cycle into a DEPTH-entry queue with flush support.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned XLEN     = DecXlen,
  parameter int unsigned DEPTH    = 2,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output decoded_t        out_dec
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  decoded_t        mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            live_q;
  logic            push, pop;

  op_e             dec_op;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  decoded_t        in_dec;

  decode_queue_inst_decoder #(
    .XLEN    (XLEN),
    .ENABLE_M(ENABLE_M)
  ) u_dec (
    .inst   (in_inst),
    .op     (dec_op),
    .rd     (dec_rd),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .imm    (dec_imm),
    .illegal(dec_illegal)
  );

  assign in_dec = '{pc: in_pc, op: dec_op, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                    imm: dec_imm, illegal: dec_illegal};

  // live_q holds in_ready low until the first clock after reset release.
  assign out_valid = (count_q != '0);
  assign in_ready  = live_q && !flush && ((count_q < FullCnt) || (out_valid && out_ready));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign out_dec   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_dec;
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: mask/match reference decoder plus queue model, two ENABLE_M variants.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int unsigned Depth = 2;

  typedef enum logic [2:0] {TR, TI, TS, TB, TU, TJ, TSH6, TSH5} tfmt_e;
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    op_e         op;
    tfmt_e       fmt;
    bit          m_ext;
  } rule_t;

  rule_t rules[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [DecXlen-1:0] in_pc = '0;
  logic ir_m, ov_m, ir_n, ov_n;
  decoded_t od_m, od_n;

  int n_cmp = 0;
  int n_fail = 0;
  decoded_t q_m[$];
  decoded_t q_n[$];
  bit started = 1'b0;
  decoded_t p;
  logic [31:0] vecs [19];

  always #5 clk = ~clk;

  decode_queue #(.XLEN(DecXlen), .DEPTH(Depth), .ENABLE_M(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_m),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov_m), .out_ready(out_ready), .out_dec(od_m)
  );

  decode_queue #(.XLEN(DecXlen), .DEPTH(Depth), .ENABLE_M(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_n),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov_n), .out_ready(out_ready), .out_dec(od_n)
  );

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input op_e op,
                     input tfmt_e fmt, input bit m_ext = 1'b0);
    rules.push_back('{mask, match, op, fmt, m_ext});
  endtask

  task automatic build_rules();
    logic [31:0] r, i, s6, u;
    r = 32'hfe00707f; i = 32'h0000707f; s6 = 32'hfc00707f; u = 32'h0000007f;
    add(u, 32'h37, LUI, TU);   add(u, 32'h17, AUIPC, TU);
    add(u, 32'h6f, JAL, TJ);   add(i, 32'h67, JALR, TI);
    add(i, 32'h63, BEQ, TB);   add(i, 32'h1063, BNE, TB);  add(i, 32'h4063, BLT, TB);
    add(i, 32'h5063, BGE, TB); add(i, 32'h6063, BLTU, TB); add(i, 32'h7063, BGEU, TB);
    add(i, 32'h03, LB, TI);    add(i, 32'h1003, LH, TI);   add(i, 32'h2003, LW, TI);
    add(i, 32'h3003, LD, TI);  add(i, 32'h4003, LBU, TI);  add(i, 32'h5003, LHU, TI);
    add(i, 32'h6003, LWU, TI);
    add(i, 32'h23, SB, TS);    add(i, 32'h1023, SH, TS);   add(i, 32'h2023, SW, TS);
    add(i, 32'h3023, SD, TS);
    add(i, 32'h13, ADDI, TI);  add(i, 32'h2013, SLTI, TI); add(i, 32'h3013, SLTIU, TI);
    add(i, 32'h4013, XORI, TI); add(i, 32'h6013, ORI, TI); add(i, 32'h7013, ANDI, TI);
    add(s6, 32'h1013, SLLI, TSH6); add(s6, 32'h5013, SRLI, TSH6);
    add(s6, 32'h40005013, SRAI, TSH6);
    add(r, 32'h33, ADD, TR);   add(r, 32'h40000033, SUB, TR); add(r, 32'h1033, SLL, TR);
    add(r, 32'h2033, SLT, TR); add(r, 32'h3033, SLTU, TR);    add(r, 32'h4033, XOR, TR);
    add(r, 32'h5033, SRL, TR); add(r, 32'h40005033, SRA, TR); add(r, 32'h6033, OR, TR);
    add(r, 32'h7033, AND, TR);
    add(i, 32'h1b, ADDIW, TI); add(r, 32'h101b, SLLIW, TSH5); add(r, 32'h501b, SRLIW, TSH5);
    add(r, 32'h4000501b, SRAIW, TSH5);
    add(r, 32'h3b, ADDW, TR);  add(r, 32'h4000003b, SUBW, TR); add(r, 32'h103b, SLLW, TR);
    add(r, 32'h503b, SRLW, TR); add(r, 32'h4000503b, SRAW, TR);
    add(r, 32'h2000033, MUL, TR, 1);  add(r, 32'h2001033, MULH, TR, 1);
    add(r, 32'h2002033, MULHSU, TR, 1); add(r, 32'h2003033, MULHU, TR, 1);
    add(r, 32'h2004033, DIV, TR, 1);  add(r, 32'h2005033, DIVU, TR, 1);
    add(r, 32'h2006033, REM, TR, 1);  add(r, 32'h2007033, REMU, TR, 1);
    add(r, 32'h200003b, MULW, TR, 1); add(r, 32'h200403b, DIVW, TR, 1);
    add(r, 32'h200503b, DIVUW, TR, 1); add(r, 32'h200603b, REMW, TR, 1);
    add(r, 32'h200703b, REMUW, TR, 1);
  endtask

  function automatic decoded_t model(input logic [31:0] w, input logic [DecXlen-1:0] pc,
                                     input bit m_en);
    decoded_t d;
    d = '0;
    d.pc = pc;
    d.op = NOP;
    d.illegal = 1'b1;
    foreach (rules[k]) begin
      if (((w & rules[k].mask) == rules[k].match) && (m_en || !rules[k].m_ext)) begin
        d.illegal = 1'b0;
        d.op  = rules[k].op;
        d.rs1 = w[19:15];
        d.rd  = (rules[k].fmt inside {TS, TB}) ? 5'd0 : w[11:7];
        d.rs2 = (rules[k].fmt inside {TR, TS, TB}) ? w[24:20] : 5'd0;
        case (rules[k].fmt)
          TI:      d.imm = 64'($signed(w[31:20]));
          TS:      d.imm = 64'($signed({w[31:25], w[11:7]}));
          TB:      d.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
          TU:      d.imm = 64'($signed({w[31:12], 12'h000}));
          TJ:      d.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
          TSH6:    d.imm = 64'(w[25:20]);
          TSH5:    d.imm = 64'(w[24:20]);
          default: d.imm = '0;
        endcase
        break;
      end
    end
    return d;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_dec(input string name, input decoded_t act, input decoded_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b pc=%h want op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b pc=%h",
               name, act.op, act.rd, act.rs1, act.rs2, act.imm, act.illegal, act.pc,
               exp.op, exp.rd, exp.rs1, exp.rs2, exp.imm, exp.illegal, exp.pc);
    end
  endtask

  // One clock: check both DUTs against the model just after the falling edge, then advance it.
  task automatic step();
    bit exp_ready, push, pop;
    #1;
    if (!rst_n) begin
      q_m.delete();
      q_n.delete();
      started = 1'b0;
    end
    exp_ready = rst_n && started && !flush &&
                ((q_m.size() < Depth) || (q_m.size() > 0 && out_ready));
    chk1("in_ready_m", ir_m, exp_ready);
    chk1("in_ready_n", ir_n, exp_ready);
    chk1("out_valid_m", ov_m, q_m.size() > 0);
    chk1("out_valid_n", ov_n, q_n.size() > 0);
    if (q_m.size() > 0) chk_dec("out_dec_m", od_m, q_m[0]);
    if (q_n.size() > 0) chk_dec("out_dec_n", od_n, q_n[0]);
    push = in_valid && exp_ready;
    pop  = (q_m.size() > 0) && out_ready && !flush;
    @(posedge clk);
    if (!rst_n || flush) begin
      q_m.delete();
      q_n.delete();
    end else begin
      if (pop) begin
        void'(q_m.pop_front());
        void'(q_n.pop_front());
      end
      if (push) begin
        q_m.push_back(model(in_inst, in_pc, 1'b1));
        q_n.push_back(model(in_inst, in_pc, 1'b0));
      end
    end
    started = rst_n;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs = '{32'h03f09093, 32'h4000d093, 32'hffffffff, 32'h022081b3, 32'h123452b7,
             32'hfffff317, 32'hffdff0ef, 32'h00008067, 32'h00009067, 32'hfe208ce3,
             32'h0020b423, 32'hff013183, 32'h402081b3, 32'h41f0d09b, 32'h0220c1bb,
             32'h20109093, 32'h00000001, 32'h0210909b, 32'h0000000f};
    build_rules();

    // Hand-computed anchors for the reference decoder.
    p = model(32'h02a00093, 64'h8000_0000, 1'b1);
    chk64("pin_addi_op", 64'(p.op), 64'(ADDI));
    chk64("pin_addi_imm", p.imm, 64'd42);
    chk64("pin_addi_rd", 64'(p.rd), 64'd1);
    p = model(32'h03f09093, 64'h0, 1'b1);
    chk64("pin_slli", {56'd0, 2'(p.op == SLLI), p.imm[5:0]}, {56'd0, 2'd1, 6'd63});
    p = model(32'h4000d093, 64'h0, 1'b1);
    chk64("pin_srai_op", 64'(p.op), 64'(SRAI));
    p = model(32'hffffffff, 64'h0, 1'b1);
    chk64("pin_bad_word", {62'(p.op), 1'(p.rd != 0), p.illegal}, {62'(NOP), 1'b0, 1'b1});
    p = model(32'h022081b3, 64'h0, 1'b1);
    chk64("pin_mul_m1", 64'(p.op), 64'(MUL));
    p = model(32'h022081b3, 64'h0, 1'b0);
    chk1("pin_mul_m0_illegal", p.illegal, 1'b1);
    p = model(32'hffdff0ef, 64'h0, 1'b1);
    chk64("pin_jal_imm", p.imm, 64'hffff_ffff_ffff_fffc);
    p = model(32'hfe208ce3, 64'h0, 1'b1);
    chk64("pin_beq_imm", p.imm, 64'hffff_ffff_ffff_fff8);
    chk64("pin_beq_rd_rs2", {59'(p.rd), p.rs2}, {59'd0, 5'd2});
    p = model(32'h123452b7, 64'h0, 1'b1);
    chk64("pin_lui_imm", p.imm, 64'h0000_0000_1234_5000);
    p = model(32'h0020b423, 64'h0, 1'b1);
    chk64("pin_sd_imm", p.imm, 64'd8);

    // Reset with a pending offer: nothing accepted, nothing valid.
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_inst = 32'h02a00093; in_pc = 64'h8000_0000;
    step();
    step();
    chk1("rst_in_ready", ir_m, 1'b0);
    chk1("rst_out_valid", ov_m, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk1("ready_after_release", ir_m, 1'b1);

    // addi x1,x0,42 with one-cycle latency.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk1("lit_addi_valid", ov_m, 1'b1);
    chk64("lit_addi_op", 64'(od_m.op), 64'(ADDI));
    chk64("lit_addi_imm", od_m.imm, 64'd42);
    chk64("lit_addi_regs", {54'd0, od_m.rd, od_m.rs1}, {54'd0, 5'd1, 5'd0});
    chk64("lit_addi_pc", od_m.pc, 64'h8000_0000);
    chk1("lit_addi_ill", od_m.illegal, 1'b0);

    // Stream of encodings at full rate.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      in_inst = vecs[i];
      in_pc = 64'h8000_0004 + 64'(4 * i);
      step();
      if (i == 3) begin
        chk64("lit_mul_m1", 64'(od_m.op), 64'(MUL));
        chk1("lit_mul_m0_ill", od_n.illegal, 1'b1);
      end
    end
    in_valid = 1'b0;
    step();
    step();

    // Fill with the consumer stalled, then push and pop every cycle.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_inst = vecs[i + 4];
      in_pc = 64'h9000_0000 + 64'(4 * i);
      step();
    end
    chk1("full_in_ready", ir_m, 1'b0);
    chk64("full_head_pc", od_m.pc, 64'h9000_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_inst = vecs[i + 10];
      in_pc = 64'ha000_0000 + 64'(4 * i);
      step();
    end
    chk1("full_pushpop_ready", ir_m, 1'b1);
    in_valid = 1'b0;
    step();
    step();

    // Flush with two queued entries and a same-cycle offer.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_inst = 32'h02a00093;
    step();
    in_inst = 32'h402081b3;
    step();
    flush = 1'b1;
    in_inst = 32'h123452b7;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk1("flush_out_valid", ov_m, 1'b0);
    step();
    in_valid = 1'b1;
    in_inst = 32'h0020b423;
    in_pc = 64'hb000_0000;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();

    // Asynchronous reset with an entry in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk1("midreset_out_valid", ov_m, 1'b0);
    rst_n = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
